// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg
// Shared types and constants for the MPMC11 port-side read request logic.
//   rdreq_state_t : read-request FSM state encoding (IDLE, REQ, WAIT_LOW, ERR)
//   MPMC11_PORTW  : width of the port-number field driven to the controller
package mpmc11_pkg;

    localparam int MPMC11_PORTW = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2,
        ERR      = 2'd3
    } rdreq_state_t;

endpackage

// File: rtl/mpmc11_port_rdreq_if.sv
// mpmc11_port_rdreq_if
// Bundles the client-side request, the controller-side request/ack handshake
// and the completion status of one MPMC11 read port.
//   cpu_req, cpu_adr[31:0] : client read request and address
//   req_o, adr_o[31:0]     : request level and held address to the controller
//   port_o[3:0]            : port number accompanying the request
//   ack_i                  : ack level from the memory-clock domain (async)
//   done_o, err_o          : completion / timeout pulses
//   busy_o                 : port is handling a request
// Modports: slave = the request block, master = the client/controller side.
interface mpmc11_port_rdreq_if;
    import mpmc11_pkg::*;

    logic                    cpu_req;
    logic [31:0]             cpu_adr;
    logic                    req_o;
    logic [31:0]             adr_o;
    logic [MPMC11_PORTW-1:0] port_o;
    logic                    ack_i;
    logic                    done_o;
    logic                    err_o;
    logic                    busy_o;

    modport slave (
        input  cpu_req, cpu_adr, ack_i,
        output req_o, adr_o, port_o, done_o, err_o, busy_o
    );

    modport master (
        output cpu_req, cpu_adr, ack_i,
        input  req_o, adr_o, port_o, done_o, err_o, busy_o
    );

endinterface

// File: rtl/mpmc11_sync2.sv
// mpmc11_sync2
// Generic two-flop synchronizer for bringing level signals into the clk domain.
//   rst : synchronous active-high reset (both stages cleared)
//   clk : destination clock
//   d   : asynchronous input, WIDTH bits
//   q   : synchronized output, WIDTH bits, two clk cycles behind d
module mpmc11_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mpmc11_port_rdreq.sv
// mpmc11_port_rdreq
// Port-side read request block: captures a client read, holds req_o/adr_o
// toward the memory controller until the (synchronized) ack rises, then
// pulses done_o and waits for the ack level to drop before accepting more.
//   rst, clk : synchronous active-high reset, single clock
//   bus      : mpmc11_port_rdreq_if.slave (cpu_req/cpu_adr in, req_o/adr_o/
//              port_o/done_o/err_o/busy_o out, ack_i async in)
// Parameters: PORT_NUM (driven on port_o), TIMEOUT (ack wait limit, cycles).
// Build option: define MPMC11_RDREQ_TIMEOUT_EN to build the timeout counter
// and ERR path; without it err_o is 0 and REQ waits indefinitely.
module mpmc11_port_rdreq
    import mpmc11_pkg::*;
#(
    parameter logic [MPMC11_PORTW-1:0] PORT_NUM = 4'd0,
    parameter int                      TIMEOUT  = 1023
) (
    input logic                 rst,
    input logic                 clk,
    mpmc11_port_rdreq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_REQ      = 2'(REQ);
    localparam logic [1:0] ST_WAIT_LOW = 2'(WAIT_LOW);
    localparam logic [1:0] ST_ERR      = 2'(ERR);

    logic        acks;
    logic        ack_rise;
    logic        ack_dly_d, ack_dly_q;
    logic [1:0]  state_d, state_q;
    logic        req_d, req_q;
    logic [31:0] adr_d, adr_q;
    logic        done_d, done_q;

    mpmc11_sync2 #(.WIDTH(1)) u_ack_sync (
        .rst (rst),
        .clk (clk),
        .d   (bus.ack_i),
        .q   (acks)
    );

    assign ack_rise = acks & ~ack_dly_q;

`ifdef MPMC11_RDREQ_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        adr_d     = adr_q;
        done_d    = 1'b0;
        ack_dly_d = acks;
`ifdef MPMC11_RDREQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A still-high ack belongs to an earlier transaction; hold off
                // until it drops so it cannot complete the new request.
                if (bus.cpu_req && !acks) begin
                    adr_d   = bus.cpu_adr;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
`ifdef MPMC11_RDREQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins a tie with the timeout.
                if (ack_rise) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_WAIT_LOW;
                end
`ifdef MPMC11_RDREQ_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    // Below CNT_MAX here, so the increment cannot wrap.
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_ERR: begin
                // Park in WAIT_LOW so a late ack is swallowed silently.
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!acks) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            adr_q     <= '0;
            done_q    <= 1'b0;
            ack_dly_q <= 1'b0;
`ifdef MPMC11_RDREQ_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            adr_q     <= adr_d;
            done_q    <= done_d;
            ack_dly_q <= ack_dly_d;
`ifdef MPMC11_RDREQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.req_o  = req_q;
    assign bus.adr_o  = adr_q;
    assign bus.port_o = PORT_NUM;
    assign bus.done_o = done_q;
    assign bus.busy_o = (state_q != ST_IDLE);
`ifdef MPMC11_RDREQ_TIMEOUT_EN
    assign bus.err_o  = err_q;
`else
    assign bus.err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mpmc11_port_rdreq.sv
// tb_mpmc11_port_rdreq
// Self-checking bench for mpmc11_port_rdreq: table of read transactions plus
// hand-written sequences for reset/stale-ack and timeout corner cases.
// Completions are checked against a scoreboard queue filled when requests
// are issued. Build with or without MPMC11_RDREQ_TIMEOUT_EN.
module tb_mpmc11_port_rdreq;
    import mpmc11_pkg::*;

    localparam logic [3:0] PN = 4'd5;
    localparam int         TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpmc11_port_rdreq_if bus();

    mpmc11_port_rdreq #(.PORT_NUM(PN), .TIMEOUT(TO)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] adr;
        logic        is_err;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    typedef struct {
        logic [31:0] adr;
        int          delay;
        int          hold;
        logic        poke;
        int          exp_done_lat;
        int          exp_busy_tail;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Completion monitor: every done/err pulse must match the oldest request.
    always @(negedge clk) begin
        if (!rst && (bus.done_o || bus.err_o)) begin
            check("done_err_exclusive", 32'(bus.done_o & bus.err_o), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'({bus.done_o, bus.err_o}), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("completion_kind", 32'(bus.err_o), 32'(e_mon.is_err));
                check("completion_adr", bus.adr_o, e_mon.adr);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = v.adr;
        sb.push_back('{v.adr, 1'b0});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("req_issue", 32'(bus.req_o), 32'd1);
        check("busy_issue", 32'(bus.busy_o), 32'd1);
        for (int i = 1; i < v.delay; i++) begin
            @(negedge clk);
            bus.cpu_req = v.poke && (i == 1);
            bus.cpu_adr = ~v.adr;
        end
        bus.cpu_req = 1'b0;
        bus.ack_i   = 1'b1;
        check("adr_hold", bus.adr_o, v.adr);
        check("req_hold", 32'(bus.req_o), 32'd1);
        repeat (v.exp_done_lat - 1) @(negedge clk);
        check("done_early", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        check("done_latency", 32'(bus.done_o), 32'd1);
        check("req_drop", 32'(bus.req_o), 32'd0);
        repeat (v.hold - v.exp_done_lat) @(negedge clk);
        check("busy_ack_high", 32'(bus.busy_o), 32'd1);
        bus.ack_i = 1'b0;
        repeat (v.exp_busy_tail - 1) @(negedge clk);
        check("busy_tail", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int drops;
        bus.cpu_req = 1'b0;
        bus.cpu_adr = '0;
        bus.ack_i   = 1'b0;

        vecs[0] = '{32'h0000_1000, 5, 6, 1'b0, 3, 3};
        vecs[1] = '{32'hDEAD_BEEF, 2, 4, 1'b0, 3, 3};
        vecs[2] = '{32'hFFFF_FFFF, 3, 20, 1'b1, 3, 3};
        vecs[3] = '{32'h8000_0001, 7, 5, 1'b1, 3, 3};

        repeat (3) @(negedge clk);
        check("rst_req", 32'(bus.req_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_adr", bus.adr_o, 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("port_num", 32'(bus.port_o), 32'(PN));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-REQ with ack high, then a deferred request behind the stale ack.
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = 32'h0000_2222;
        sb.push_back('{32'h0000_2222, 1'b0});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("mid_req_issue", 32'(bus.req_o), 32'd1);
        @(negedge clk);
        bus.ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_req", 32'(bus.req_o), 32'd0);
        check("midrst_adr", bus.adr_o, 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_done", 32'(bus.done_o), 32'd0);
        repeat (3) @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = 32'h0000_3333;
        repeat (4) @(negedge clk);
        check("stale_defer_req", 32'(bus.req_o), 32'd0);
        check("stale_defer_busy", 32'(bus.busy_o), 32'd0);
        bus.ack_i = 1'b0;
        sb.push_back('{32'h0000_3333, 1'b0});
        repeat (2) @(negedge clk);
        check("stale_still_wait", 32'(bus.req_o), 32'd0);
        @(negedge clk);
        check("stale_release", 32'(bus.req_o), 32'd1);
        check("stale_adr", bus.adr_o, 32'h0000_3333);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        bus.ack_i = 1'b1;
        repeat (3) @(negedge clk);
        check("stale_done", 32'(bus.done_o), 32'd1);
        bus.ack_i = 1'b0;
        repeat (4) @(negedge clk);
        check("stale_idle", 32'(bus.busy_o), 32'd0);

`ifdef MPMC11_RDREQ_TIMEOUT_EN
        // Timeout with a late ack that must be absorbed.
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = 32'h0000_4444;
        sb.push_back('{32'h0000_4444, 1'b1});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            if (i == 16) bus.ack_i = 1'b1;
        end
        @(negedge clk);
        check("to_err_early", 32'(bus.err_o), 32'd0);
        check("to_req_hold", 32'(bus.req_o), 32'd1);
        @(negedge clk);
        check("to_err", 32'(bus.err_o), 32'd1);
        check("to_req_drop", 32'(bus.req_o), 32'd0);
        check("to_no_done", 32'(bus.done_o), 32'd0);
        repeat (4) @(negedge clk);
        check("to_wait_low_busy", 32'(bus.busy_o), 32'd1);
        bus.ack_i = 1'b0;
        repeat (3) @(negedge clk);
        check("to_idle", 32'(bus.busy_o), 32'd0);

        // Ack rise in the same cycle the counter reaches TIMEOUT.
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = 32'h0000_5555;
        sb.push_back('{32'h0000_5555, 1'b0});
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            if (i == 15) bus.ack_i = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("race_done", 32'(bus.done_o), 32'd1);
        check("race_err", 32'(bus.err_o), 32'd0);
        repeat (2) @(negedge clk);
        bus.ack_i = 1'b0;
        repeat (4) @(negedge clk);
        check("race_idle", 32'(bus.busy_o), 32'd0);
`else
        // No timeout logic: request must stay up indefinitely.
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.cpu_adr = 32'h0000_6666;
        sb.push_back('{32'h0000_6666, 1'b0});
        @(negedge clk);
        bus.cpu_req = 1'b0;
        drops = 0;
        repeat (5000) begin
            @(negedge clk);
            if (!bus.req_o || bus.err_o) drops++;
        end
        check("no_timeout", 32'(drops), 32'd0);
        bus.ack_i = 1'b1;
        repeat (3) @(negedge clk);
        check("late_done", 32'(bus.done_o), 32'd1);
        bus.ack_i = 1'b0;
        repeat (4) @(negedge clk);
        check("late_idle", 32'(bus.busy_o), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpmc11_port_rdreq.md
MPMC11_PORT_RDREQ -- requirements
Module: mpmc11_port_rdreq

Interface
REQ-001 Parameter PORT_NUM, default 4'd0, port number driven on port_o with every request.
REQ-002 Parameter TIMEOUT, default 1023, number of clk cycles to wait for an ack before declaring an error.
REQ-003 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port clk  input  1  port-side clock; this block has one clock, and all state is on the rising edge of clk.
REQ-005 Port cpu_req  input  1  read request from the port client; sampled only in IDLE.
REQ-006 Port cpu_adr  input  32  read address, captured with cpu_req.
REQ-007 Port req_o  output  1  read request level to the memory controller, held until completion.
REQ-008 Port adr_o  output  32  captured address; stable while req_o=1.
REQ-009 Port port_o  output  4  equals PORT_NUM.
REQ-010 Port ack_i  input  1  read ack level from the memory-clock domain; asynchronous to clk.
REQ-011 Port done_o  output  1  single-cycle pulse that marks read completion.
REQ-012 Port err_o  output  1  single-cycle pulse that marks a timeout.
REQ-013 Port busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 ack_i SHALL pass through a two-flop synchronizer; only the synchronized value (acks) is used.
REQ-015 A rising edge of acks SHALL be detected by comparing acks with a one-cycle-delayed copy of acks (ack_rise).
REQ-016 FSM states: IDLE, REQ, WAIT_LOW, ERR.
REQ-017 IDLE: when cpu_req=1 and acks=0, the block SHALL capture cpu_adr into adr_o, assert req_o, clear the timeout counter, and go to REQ.
REQ-018 IDLE with cpu_req=1 and acks=1 (stale ack): the request SHALL be deferred until acks=0.
REQ-019 REQ: on ack_rise, the block SHALL drop req_o, pulse done_o for one cycle, and go to WAIT_LOW.
REQ-020 Latency: done_o SHALL assert exactly 3 clk cycles after the ack_i rising edge that meets setup time (2 synchronizer stages plus 1 registered output cycle).
REQ-021 WAIT_LOW: the block SHALL go to IDLE when acks=0, so no second completion can come from the same ack level.
REQ-022 cpu_req seen while in REQ or WAIT_LOW SHALL be ignored (not queued); the client must retry after busy_o falls.
REQ-023 If ack_rise and timeout expiry occur in the same cycle, the ack SHALL win: done_o pulses and err_o stays 0.
REQ-024 Timeout counter: 10 bits wide, set by $clog2(TIMEOUT+1); increments each REQ cycle; saturates, never wraps.
REQ-025 When the counter reaches TIMEOUT in REQ, the block SHALL drop req_o, pulse err_o for one cycle, and go to ERR.
REQ-026 ERR SHALL go to WAIT_LOW on the next cycle, so a late ack is absorbed without a done_o pulse.
REQ-027 done_o and err_o SHALL never be high in the same cycle.

Reset
REQ-028 Reset values: req_o=0, adr_o=0, done_o=0, err_o=0, busy_o=0, both synchronizer flops=0, edge-detect flop=0, counter=0, state=IDLE.
REQ-029 Reset asserted mid-transaction SHALL abandon the request with no done_o or err_o pulse; a stale ack that arrives after reset is handled by REQ-018.

Configuration
REQ-030 Macro MPMC11_RDREQ_TIMEOUT_EN defined: the timeout counter, the ERR state and err_o behave as in REQ-024 to REQ-026.
REQ-031 Macro MPMC11_RDREQ_TIMEOUT_EN not defined: no counter is built, ERR is never entered, err_o is tied to 0, and REQ waits forever for an ack.

Structure
REQ-032 Package mpmc11_pkg SHALL hold the rdreq_state_t enum (IDLE, REQ, WAIT_LOW, ERR) and the port-number width constant MPMC11_PORTW=4.
REQ-033 Sub-module mpmc11_sync2 SHALL be a generic two-flop synchronizer with parameterized width and rst, clk, d, q ports; it is instantiated once for ack_i.

Verification
REQ-034 Basic read: cpu_req pulse with adr 32'h0000_1000, ack_i rises 5 cycles later -> req_o high from the cycle after cpu_req until the done cycle; done_o pulses once, 3 cycles after ack_i; adr_o=32'h0000_1000 throughout.
REQ-035 Long ack: ack_i held high for 20 cycles -> exactly one done_o pulse; busy_o stays 1 until 2 cycles after ack_i falls.
REQ-036 Timeout (macro defined, TIMEOUT=16): no ack -> err_o pulses at counter 16; a late ack_i produces no done_o; the block returns to IDLE once acks=0.
REQ-037 Race: ack_rise in the same cycle the counter hits TIMEOUT -> done_o=1, err_o=0.
REQ-038 Reset mid-REQ: rst for 1 cycle with ack_i already high -> all outputs 0; a new cpu_req is not issued (req_o stays 0) until ack_i falls.
REQ-039 Macro undefined: no ack for 5000 cycles -> req_o stays 1 and err_o stays 0.
